timesharing_and_vector_pipe: RTL and testbench

TIMESHARING_AND_VECTOR_PIPE -- requirements
Module: timesharing_and_vector_pipe

---
 rtl/tsm_pkg.sv | 33 +++
 rtl/tsm_and_lane.sv | 52 +++++
 rtl/timesharing_and_vector_pipe.sv | 108 ++++++++++
 tb/tb_timesharing_and_vector_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsm_pkg.sv
// Shared slicing constants and per-lane register/output layouts for the
// first-order time-sharing masked AND pipeline.
package tsm_pkg;

    localparam int unsigned RAND_PER_LANE  = 3;
    localparam int unsigned RCOMP_PER_LANE = 2;

    // Stage-1 register contents of one lane.
    typedef struct packed {
        logic a1;
        logic b1;
        logic ab1;
        logic r1;
        logic r2;
        logic r3;
        logic a2;
        logic b2;
    } s1_lane_t;

    // Output shares of one lane.
    typedef struct packed {
        logic ab1;
        logic ab2;
        logic a1;
        logic a2;
        logic b1;
        logic b2;
    } out_lane_t;

    localparam int unsigned S1_W  = $bits(s1_lane_t);
    localparam int unsigned OUT_W = $bits(out_lane_t);

endpackage

// File: rtl/tsm_and_lane.sv
// One masked AND lane: refresh + mask pre-stage feeding the stage-1 register,
// and the share recombination that reads it back.
module tsm_and_lane
    import tsm_pkg::*;
(
    input  logic                      a_share1_i,
    input  logic                      a_share2_i,
    input  logic                      b_share1_i,
    input  logic                      b_share2_i,
    input  logic [RAND_PER_LANE-1:0]  rand_i,
    input  logic [RCOMP_PER_LANE-1:0] rcomp_i,
    input  logic [S1_W-1:0]           s1_q_i,
    output logic [S1_W-1:0]           s1_d_o,
    output logic [OUT_W-1:0]          out_o
);

    logic      a1, a2, b1, b2;
    s1_lane_t  nxt;
    s1_lane_t  cur;
    out_lane_t res;

    // Share-1 and share-2 domains stay apart here; only masks cross them.
    always_comb begin
        a1      = a_share1_i ^ rcomp_i[0];
        a2      = a_share2_i ^ rcomp_i[0];
        b1      = b_share1_i ^ rcomp_i[1];
        b2      = b_share2_i ^ rcomp_i[1];
        nxt.a1  = a1 ^ rand_i[0];
        nxt.b1  = b1 ^ rand_i[1];
        nxt.ab1 = (a1 & b1) ^ rand_i[2];
        nxt.r1  = rand_i[0];
        nxt.r2  = rand_i[1];
        nxt.r3  = rand_i[2];
        nxt.a2  = a2;
        nxt.b2  = b2;
    end

    assign s1_d_o = nxt;
    assign cur    = s1_q_i;

    always_comb begin
        res.ab1 = cur.ab1 ^ (cur.a1 & cur.b2) ^ (cur.b1 & cur.a2);
        res.ab2 = cur.r3 ^ (cur.r1 & cur.b2) ^ (cur.r2 & cur.a2) ^ (cur.a2 & cur.b2);
        res.a1  = cur.a1;
        res.a2  = cur.r1 ^ cur.a2;
        res.b1  = cur.b1;
        res.b2  = cur.r2 ^ cur.b2;
    end

    assign out_o = res;

endmodule

// File: rtl/timesharing_and_vector_pipe.sv
// WIDTH-lane first-order masked AND with elastic valid/ready pipeline;
// OUT_REG adds a second skid-free register stage on the outputs.
module timesharing_and_vector_pipe
    import tsm_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned OUT_REG = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    a_share1,
    input  logic [WIDTH-1:0]                    a_share2,
    input  logic [WIDTH-1:0]                    b_share1,
    input  logic [WIDTH-1:0]                    b_share2,
    input  logic [RAND_PER_LANE*WIDTH-1:0]      rand_bit,
    input  logic [RCOMP_PER_LANE*WIDTH-1:0]     rand_composable_bit,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    output_ab_share1,
    output logic [WIDTH-1:0]                    output_ab_share2,
    output logic [WIDTH-1:0]                    output_a_share1,
    output logic [WIDTH-1:0]                    output_a_share2,
    output logic [WIDTH-1:0]                    output_b_share1,
    output logic [WIDTH-1:0]                    output_b_share2
);

    logic [WIDTH-1:0][S1_W-1:0]  s1_d;
    logic [WIDTH-1:0][S1_W-1:0]  s1_q;
    logic [WIDTH-1:0][OUT_W-1:0] res_c;
    logic [WIDTH-1:0][OUT_W-1:0] out_sel;
    logic                        s1_valid_q;
    logic                        s1_valid_d;
    logic                        s1_advance;
    logic                        accept;

    assign accept     = in_valid & in_ready;
    assign in_ready   = ~s1_valid_q | s1_advance;
    assign s1_valid_d = accept | (s1_valid_q & ~s1_advance);

    // Rand inputs are only captured on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        out_lane_t lane_out;

        tsm_and_lane u_lane (
            .a_share1_i (a_share1[i]),
            .a_share2_i (a_share2[i]),
            .b_share1_i (b_share1[i]),
            .b_share2_i (b_share2[i]),
            .rand_i     (rand_bit[RAND_PER_LANE*i +: RAND_PER_LANE]),
            .rcomp_i    (rand_composable_bit[RCOMP_PER_LANE*i +: RCOMP_PER_LANE]),
            .s1_q_i     (s1_q[i]),
            .s1_d_o     (s1_d[i]),
            .out_o      (res_c[i])
        );

        assign lane_out            = out_sel[i];
        assign output_ab_share1[i] = lane_out.ab1;
        assign output_ab_share2[i] = lane_out.ab2;
        assign output_a_share1[i]  = lane_out.a1;
        assign output_a_share2[i]  = lane_out.a2;
        assign output_b_share1[i]  = lane_out.b1;
        assign output_b_share2[i]  = lane_out.b2;
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                        s2_valid_q;
        logic                        s2_valid_d;
        logic [WIDTH-1:0][OUT_W-1:0] s2_q;

        // Stage 1 may move whenever stage 2 is empty or draining.
        assign s1_advance = ~s2_valid_q | out_ready;
        assign s2_valid_d = s1_advance ? s1_valid_q : s2_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_q       <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                if (s1_valid_q & s1_advance) begin
                    s2_q <= res_c;
                end
            end
        end

        assign out_sel   = s2_q;
        assign out_valid = s2_valid_q;
    end else begin : g_out_comb
        assign s1_advance = out_ready;
        assign out_sel    = res_c;
        assign out_valid  = s1_valid_q;
    end

endmodule

// File: tb/tb_timesharing_and_vector_pipe.sv
// Self-checking bench: table vectors, exhaustive single-lane sweep, streaming,
// stall/reset corner cases and randomized traffic against an unshared model.
module tb_timesharing_and_vector_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       iv, ir, ov, ordy;
    logic [7:0]       a_s1, a_s2, b_s1, b_s2;
    logic [23:0]      rnd;
    logic [15:0]      rc;
    logic [1:0][7:0]  o_ab1, o_ab2, o_a1, o_a2, o_b1, o_b2;

    logic             w_iv, w_ir, w_ov, w_or;
    logic             w_a1, w_a2, w_b1, w_b2;
    logic [2:0]       w_rnd;
    logic [1:0]       w_rc;
    logic             w_oab1, w_oab2, w_oa1, w_oa2, w_ob1, w_ob2;

    timesharing_and_vector_pipe #(.WIDTH(8), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a_share1(a_s1), .a_share2(a_s2), .b_share1(b_s1), .b_share2(b_s2),
        .rand_bit(rnd), .rand_composable_bit(rc),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .output_ab_share1(o_ab1[0]), .output_ab_share2(o_ab2[0]),
        .output_a_share1(o_a1[0]), .output_a_share2(o_a2[0]),
        .output_b_share1(o_b1[0]), .output_b_share2(o_b2[0])
    );

    timesharing_and_vector_pipe #(.WIDTH(8), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a_share1(a_s1), .a_share2(a_s2), .b_share1(b_s1), .b_share2(b_s2),
        .rand_bit(rnd), .rand_composable_bit(rc),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .output_ab_share1(o_ab1[1]), .output_ab_share2(o_ab2[1]),
        .output_a_share1(o_a1[1]), .output_a_share2(o_a2[1]),
        .output_b_share1(o_b1[1]), .output_b_share2(o_b2[1])
    );

    timesharing_and_vector_pipe #(.WIDTH(1), .OUT_REG(0)) u_dutw (
        .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir),
        .a_share1(w_a1), .a_share2(w_a2), .b_share1(w_b1), .b_share2(w_b2),
        .rand_bit(w_rnd), .rand_composable_bit(w_rc),
        .out_valid(w_ov), .out_ready(w_or),
        .output_ab_share1(w_oab1), .output_ab_share2(w_oab2),
        .output_a_share1(w_oa1), .output_a_share2(w_oa2),
        .output_b_share1(w_ob1), .output_b_share2(w_ob2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Unshared view {a&b, a, b} of a W8 instance.
    function automatic logic [23:0] unsh(input int d);
        return {o_ab1[d] ^ o_ab2[d], o_a1[d] ^ o_a2[d], o_b1[d] ^ o_b2[d]};
    endfunction

    function automatic logic [47:0] obus(input int d);
        return {o_ab1[d], o_ab2[d], o_a1[d], o_a2[d], o_b1[d], o_b2[d]};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [23:0] r,
                         input logic [15:0] c, input logic [7:0] ma, input logic [7:0] mb);
        a_s1 = ma;
        a_s2 = a ^ ma;
        b_s1 = mb;
        b_s2 = b ^ mb;
        rnd  = r;
        rc   = c;
    endtask

    task automatic drive_rand(input logic [7:0] a, input logic [7:0] b);
        drive(a, b, 24'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [23:0] r;
        logic [15:0] c;
        logic [7:0]  ma;
        logic [7:0]  mb;
        logic [7:0]  exp_ab;
    } vec_t;

    vec_t tbl[8];

    // Randomized traffic on one W8 instance; the model is a FIFO of unshared results.
    task automatic run_random(input int d, input int ncyc);
        logic [23:0] q[$];
        logic [23:0] e;
        logic [47:0] snap;
        logic        stall;
        logic [7:0]  a, b;
        stall = 1'b0;
        snap  = '0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (stall) chk("rand_stall_hold", 64'({ov[d], obus(d)}), 64'({1'b1, snap}));
            a = 8'($urandom);
            b = 8'($urandom);
            drive_rand(a, b);
            if (cyc < ncyc - 8) begin
                iv[d]   = ($urandom % 4) != 0;
                ordy[d] = ($urandom % 3) != 0;
            end else begin
                iv[d]   = 1'b0;
                ordy[d] = 1'b1;
            end
            #1;
            if (ov[d] && ordy[d]) begin
                chk("rand_out_pending", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rand_data", 64'(unsh(d)), 64'(e));
                end
            end
            if (iv[d] && ir[d]) q.push_back({a & b, a, b});
            stall = ov[d] && !ordy[d];
            snap  = obus(d);
        end
        chk("rand_drained", 64'(q.size()), 64'(0));
        iv[d] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [23:0] exp_b2b[20];
        logic [23:0] xexp, yexp;
        logic [47:0] snap;
        logic [23:0] s1z, s1o;
        logic [7:0]  a, b;
        logic [3:0]  s4;
        logic [4:0]  r5;
        logic        wa, wb;

        tbl[0] = '{8'hA5, 8'h3C, 24'h5A1F33, 16'hC0DE, 8'h6B, 8'h91, 8'h24};
        tbl[1] = '{8'hFF, 8'hFF, 24'h000000, 16'h0000, 8'h00, 8'h00, 8'hFF};
        tbl[2] = '{8'h00, 8'hFF, 24'hFFFFFF, 16'hFFFF, 8'hFF, 8'hFF, 8'h00};
        tbl[3] = '{8'hF0, 8'h0F, 24'h123456, 16'h789A, 8'h3C, 8'hC3, 8'h00};
        tbl[4] = '{8'hAA, 8'h55, 24'hA5A5A5, 16'h5A5A, 8'hAA, 8'h55, 8'h00};
        tbl[5] = '{8'hC3, 8'h81, 24'h0F0F0F, 16'hF0F0, 8'h7E, 8'h18, 8'h81};
        tbl[6] = '{8'h5A, 8'h7E, 24'hDEADBE, 16'hBEEF, 8'h01, 8'h80, 8'h5A};
        tbl[7] = '{8'h13, 8'h37, 24'h777777, 16'h3333, 8'hFE, 8'hEF, 8'h13};

        rst = 1'b1; iv = '0; ordy = '0;
        drive(8'h00, 8'h00, 24'h0, 16'h0, 8'h00, 8'h00);
        w_iv = 1'b0; w_or = 1'b0; w_a1 = 1'b0; w_a2 = 1'b0; w_b1 = 1'b0; w_b2 = 1'b0;
        w_rnd = '0; w_rc = '0;

        // Reset state, observed right after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid0", 64'(ov[0]), 64'(0));
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_out_valid", 64'(ov[d]), 64'(0));
            chk("reset_outputs_zero", 64'(obus(d)), 64'(0));
            chk("reset_in_ready", 64'(ir[d]), 64'(1));
        end
        chk("reset_w1", 64'({w_ov, w_ir, w_oab1, w_oab2, w_oa1, w_oa2, w_ob1, w_ob2}), 64'(8'b0100_0000));

        // Table vectors, one transfer each, OUT_REG=0.
        ordy[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].c, tbl[i].ma, tbl[i].mb);
            iv[0] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("tbl_out_valid", 64'(ov[0]), 64'(1));
            chk("tbl_result", 64'(unsh(0)), 64'({tbl[i].exp_ab, tbl[i].a, tbl[i].b}));
            iv[0] = 1'b0;
        end
        @(negedge clk);
        chk("tbl_idle_after", 64'(ov[0]), 64'(0));

        // Exhaustive single lane: 16 share combos x 32 mask combos, streaming.
        w_or = 1'b1;
        for (int sh = 0; sh < 16; sh++) begin
            for (int r = 0; r < 32; r++) begin
                s4 = 4'(sh);
                r5 = 5'(r);
                {w_a1, w_a2, w_b1, w_b2} = s4;
                {w_rnd, w_rc} = r5;
                w_iv = 1'b1;
                @(posedge clk);
                @(negedge clk);
                wa = w_a1 ^ w_a2;
                wb = w_b1 ^ w_b2;
                chk("exhaustive_w1",
                    64'({w_ov, w_oab1 ^ w_oab2, w_oa1 ^ w_oa2, w_ob1 ^ w_ob2}),
                    64'({1'b1, wa & wb, wa, wb}));
            end
        end
        w_iv = 1'b0;

        // 20 back-to-back transfers through the 2-stage variant.
        ordy[1] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 23; k++) begin
            chk("b2b_out_valid", 64'(ov[1]), 64'((k >= 2 && k <= 21) ? 1 : 0));
            if (k >= 2 && k <= 21) chk("b2b_data", 64'(unsh(1)), 64'(exp_b2b[k-2]));
            if (k < 20) begin
                a = 8'($urandom);
                b = 8'($urandom);
                drive_rand(a, b);
                exp_b2b[k] = {a & b, a, b};
                iv[1] = 1'b1;
            end else begin
                iv[1] = 1'b0;
            end
            @(negedge clk);
        end

        // Stall with a full stage, then release with simultaneous accept/drain.
        ordy[0] = 1'b0;
        drive_rand(8'h6C, 8'hB7);
        xexp = {8'h6C & 8'hB7, 8'h6C, 8'hB7};
        iv[0] = 1'b1;
        @(negedge clk);
        chk("stall_first_valid", 64'(ov[0]), 64'(1));
        chk("stall_first_data", 64'(unsh(0)), 64'(xexp));
        drive_rand(8'h9E, 8'h4D);
        yexp = {8'h9E & 8'h4D, 8'h9E, 8'h4D};
        #1;
        chk("stall_in_ready", 64'(ir[0]), 64'(0));
        snap = obus(0);
        repeat (3) begin
            @(negedge clk);
            rnd = 24'($urandom);
            rc  = 16'($urandom);
            #1;
            chk("stall_in_ready_hold", 64'(ir[0]), 64'(0));
            chk("stall_outputs_hold", 64'({ov[0], obus(0)}), 64'({1'b1, snap}));
        end
        ordy[0] = 1'b1;
        #1;
        chk("release_in_ready", 64'(ir[0]), 64'(1));
        @(negedge clk);
        iv[0] = 1'b0;
        chk("release_next_valid", 64'(ov[0]), 64'(1));
        chk("release_next_data", 64'(unsh(0)), 64'(yexp));
        @(negedge clk);
        chk("release_drained", 64'(ov[0]), 64'(0));

        // Reset pulse with both stages of the 2-stage variant occupied.
        ordy[1] = 1'b0;
        drive_rand(8'h3A, 8'hF1);
        xexp = {8'h3A & 8'hF1, 8'h3A, 8'hF1};
        iv[1] = 1'b1;
        @(negedge clk);
        drive_rand(8'hC5, 8'h2E);
        @(negedge clk);
        chk("prerst_valid", 64'(ov[1]), 64'(1));
        chk("prerst_data", 64'(unsh(1)), 64'(xexp));
        chk("prerst_full", 64'(ir[1]), 64'(0));
        iv[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ordy[1] = 1'b1;
        #1;
        chk("postrst_valid", 64'(ov[1]), 64'(0));
        chk("postrst_outputs", 64'(obus(1)), 64'(0));
        chk("postrst_in_ready", 64'(ir[1]), 64'(1));
        repeat (3) begin
            @(negedge clk);
            chk("postrst_no_stale", 64'(ov[1]), 64'(0));
        end

        // Masking: same data under different mask patterns.
        ordy[0] = 1'b1;
        for (int run = 0; run < 3; run++) begin
            @(negedge clk);
            case (run)
                0:       drive(8'hA5, 8'h3C, 24'h000000, 16'h0000, 8'h0F, 8'hF0);
                1:       drive(8'hA5, 8'h3C, 24'hFFFFFF, 16'h0000, 8'h0F, 8'hF0);
                default: drive(8'hA5, 8'h3C, 24'hFFFFFF, 16'hFFFF, 8'h0F, 8'hF0);
            endcase
            iv[0] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            iv[0] = 1'b0;
            chk("mask_result", 64'({ov[0], unsh(0)}), 64'({1'b1, 8'h24, 8'hA5, 8'h3C}));
            if (run == 0) s1z = {o_ab1[0], o_a1[0], o_b1[0]};
            if (run == 1) s1o = {o_ab1[0], o_a1[0], o_b1[0]};
        end
        chk("mask_share1_differs", 64'(s1z != s1o), 64'(1));

        // Randomized handshake traffic on both latency variants.
        run_random(0, 300);
        run_random(1, 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
